// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM and MEM/WB registers plus a single-beat data bus master
// with byte-lane steering, load extension, misalignment detection and a bus timeout.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_result_2,
  input  logic        load_inst,
  input  logic        store_inst,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [4:0]  dest_reg,
  input  logic        dest_reg_valid,
  output logic        stall,
  output logic [31:0] result_from_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dest_reg,
  output logic        wb_dest_reg_valid,
  output logic        mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;

  logic        xm_valid_reg;
  logic [31:0] xm_result_reg;
  logic [31:0] xm_data_reg;
  logic        xm_load_reg;
  logic        xm_store_reg;
  logic [1:0]  xm_size_reg;
  logic        xm_unsigned_reg;
  logic [4:0]  xm_rd_reg;
  logic        xm_rd_valid_reg;

  logic [1:0]  lo;
  logic        is_byte, is_half, is_word;
  logic        misalign, mem_op, aligned_op, bad_op, timeout_hit, err_next;
  logic [3:0]  byte_be;
  logic [7:0]  rd_byte [4];
  logic [7:0]  load_b;
  logic [15:0] load_h;
  logic [31:0] load_val;
  logic [31:0] wb_result_next;

  assign lo      = xm_result_reg[1:0];
  assign is_byte = (xm_size_reg == 2'd0);
  assign is_half = (xm_size_reg == 2'd1);
  assign is_word = xm_size_reg[1];

  assign misalign    = (is_half & lo[0]) | (is_word & (lo != 2'b00));
  assign mem_op      = xm_valid_reg & (xm_load_reg | xm_store_reg);
  assign aligned_op  = mem_op & ~misalign;
  assign bad_op      = mem_op & misalign;
  // Counter holds the number of wait cycles already spent, including the IDLE one.
  assign timeout_hit = (state_reg == BUSY) && (cnt_reg == TMO_LAST) && !dmem_ack;
  assign err_next    = bad_op | timeout_hit;

  assign stall              = aligned_op & ~dmem_ack & ~timeout_hit;
  assign dmem_req           = aligned_op;
  assign dmem_we            = aligned_op & xm_store_reg;
  assign dmem_addr          = {xm_result_reg[31:2], 2'b00};
  assign result_from_ex_mem = xm_result_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_be[gi] = (lo == 2'(gi));
    assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
  end

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = xm_data_reg;
    if (is_byte) begin
      dmem_be    = byte_be;
      dmem_wdata = {4{xm_data_reg[7:0]}};
    end else if (is_half) begin
      dmem_be    = lo[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{xm_data_reg[15:0]}};
    end
  end

  assign load_b = rd_byte[lo];
  assign load_h = lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_val = dmem_rdata;
    if (is_byte)
      load_val = {{24{~xm_unsigned_reg & load_b[7]}}, load_b};
    else if (is_half)
      load_val = {{16{~xm_unsigned_reg & load_h[15]}}, load_h};
  end

  assign wb_result_next = (xm_load_reg & aligned_op) ? load_val : xm_result_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: if (aligned_op && !dmem_ack) begin
          state_reg <= BUSY;
          cnt_reg   <= 8'd1;
        end
        BUSY: if (dmem_ack || timeout_hit) begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
        end else begin
          cnt_reg <= cnt_reg + 8'd1;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xm_valid_reg      <= 1'b0;
      xm_result_reg     <= 32'd0;
      xm_data_reg       <= 32'd0;
      xm_load_reg       <= 1'b0;
      xm_store_reg      <= 1'b0;
      xm_size_reg       <= 2'd0;
      xm_unsigned_reg   <= 1'b0;
      xm_rd_reg         <= 5'd0;
      xm_rd_valid_reg   <= 1'b0;
      wb_valid          <= 1'b0;
      wb_result         <= 32'd0;
      wb_dest_reg       <= 5'd0;
      wb_dest_reg_valid <= 1'b0;
      mem_err           <= 1'b0;
    end else begin
      // A faulting op never stalls, so the error pulse lines up with its writeback.
      mem_err <= err_next;
      if (!stall) begin
        xm_valid_reg      <= in_valid;
        xm_result_reg     <= ex_result;
        xm_data_reg       <= ex_result_2;
        xm_load_reg       <= load_inst;
        xm_store_reg      <= store_inst;
        xm_size_reg       <= ls_size;
        xm_unsigned_reg   <= ls_unsigned;
        xm_rd_reg         <= dest_reg;
        xm_rd_valid_reg   <= dest_reg_valid;
        wb_valid          <= xm_valid_reg;
        wb_result         <= wb_result_next;
        wb_dest_reg       <= xm_rd_reg;
        wb_dest_reg_valid <= xm_valid_reg & xm_rd_valid_reg & ~err_next;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a bus responder checks each access and its stall
// length, a writeback monitor pops expected results as the MEM/WB register advances.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_result_2 = '0;
  logic        load_inst = 1'b0;
  logic        store_inst = 1'b0;
  logic [1:0]  ls_size = '0;
  logic        ls_unsigned = 1'b0;
  logic [4:0]  dest_reg = '0;
  logic        dest_reg_valid = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_dest_reg_valid, mem_err;
  logic [31:0] result_from_ex_mem, dmem_addr, dmem_wdata, wb_result;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_dest_reg;

  mem_stage #(.TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .ex_result(ex_result), .ex_result_2(ex_result_2),
    .load_inst(load_inst), .store_inst(store_inst),
    .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .dest_reg(dest_reg), .dest_reg_valid(dest_reg_valid),
    .stall(stall), .result_from_ex_mem(result_from_ex_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_dest_reg(wb_dest_reg),
    .wb_dest_reg_valid(wb_dest_reg_valid), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    int          exp_stall;
  } bus_t;

  typedef struct {
    logic [31:0] result;
    logic        chk_result;
    logic [4:0]  rd;
    logic        rd_valid;
    logic        err;
  } wb_t;

  bus_t bus_q[$];
  wb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                         input int exp_stall);
    bus_t b;
    b.addr = addr; b.we = we; b.be = be; b.wdata = wdata;
    b.delay = delay; b.rdata = rdata; b.exp_stall = exp_stall;
    bus_q.push_back(b);
  endtask

  task automatic exp_wb(input logic [31:0] result, input logic chk, input logic [4:0] rd,
                        input logic rdv, input logic err);
    wb_t w;
    w.result = result; w.chk_result = chk; w.rd = rd; w.rd_valid = rdv; w.err = err;
    sb_q.push_back(w);
  endtask

  // Called at negedge+3; returns at negedge+3 after the edge that captured the op.
  task automatic issue(input logic v, input logic [31:0] r, input logic [31:0] r2,
                       input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [4:0] rd, input logic rdv);
    bit s;
    int guard;
    guard = 0;
    in_valid = v; ex_result = r; ex_result_2 = r2; load_inst = ld; store_inst = st;
    ls_size = sz; ls_unsigned = uns; dest_reg = rd; dest_reg_valid = rdv;
    do begin
      s = stall;
      @(posedge clock);
      @(negedge clock);
      #3;
      guard++;
    end while (s && guard < 100);
    if (s) check("issue_timeout", 32'd1, 32'd0);
    in_valid = 1'b0; load_inst = 1'b0; store_inst = 1'b0;
  endtask

  // Bus responder: checks each new access, acks after its delay, counts stall cycles.
  initial begin
    bus_t cur;
    bit   busy;
    int   waited, scnt;
    busy = 0; waited = 0; scnt = 0;
    cur.addr = '0; cur.we = 0; cur.be = '0; cur.wdata = '0;
    cur.delay = 0; cur.rdata = '0; cur.exp_stall = -1;
    forever begin
      @(negedge clock);
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      if (!reset_n) begin
        busy = 0;
        continue;
      end
      if (dmem_req) begin
        if (!busy) begin
          if (bus_q.size() == 0) begin
            check("unexpected_dmem_req", 32'd1, 32'd0);
            cur.delay = 0; cur.exp_stall = -1; cur.addr = dmem_addr;
            cur.we = dmem_we; cur.be = dmem_be;
          end else begin
            cur = bus_q.pop_front();
            check("dmem_addr", dmem_addr, cur.addr);
            check("dmem_we", 32'(dmem_we), 32'(cur.we));
            check("dmem_be", 32'(dmem_be), 32'(cur.be));
            if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
          end
          busy = 1; waited = 0; scnt = 0;
        end else begin
          check("dmem_addr_stable", dmem_addr, cur.addr);
          check("dmem_be_stable", 32'(dmem_be), 32'(cur.be));
        end
        if (waited == cur.delay) begin
          dmem_ack = 1'b1;
          dmem_rdata = cur.rdata;
        end else begin
          waited++;
        end
        #1;
        if (stall) begin
          scnt++;
        end else begin
          busy = 0;
          if (cur.exp_stall >= 0) check("stall_cycles", 32'(scnt), 32'(cur.exp_stall));
          $display("bus: addr=0x%08h we=%0b be=%04b wdata=0x%08h stall_cycles=%0d",
                   cur.addr, cur.we, cur.be, dmem_wdata, scnt);
        end
      end
    end
  end

  // Writeback monitor: pops one expectation per valid MEM/WB update.
  initial begin
    bit  adv;
    wb_t e;
    adv = 0;
    forever begin
      @(negedge clock);
      if (adv && reset_n && wb_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wb_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.chk_result) check("wb_result", wb_result, e.result);
          check("wb_dest_reg", 32'(wb_dest_reg), 32'(e.rd));
          check("wb_dest_reg_valid", 32'(wb_dest_reg_valid), 32'(e.rd_valid));
          check("mem_err", 32'(mem_err), 32'(e.err));
          $display("wb: result=0x%08h rd=%0d rd_valid=%0b mem_err=%0b",
                   wb_result, wb_dest_reg, wb_dest_reg_valid, mem_err);
        end
      end else if (reset_n && mem_err) begin
        check("mem_err_spurious", 32'(mem_err), 32'd0);
      end
      #2;
      adv = reset_n && !stall;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, failures=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_dest_reg_valid", 32'(wb_dest_reg_valid), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_result_from_ex_mem", result_from_ex_mem, 32'd0);
    @(negedge clock);
    #4 reset_n = 1'b1;
    @(negedge clock);
    #3;

    // word load, zero-wait ack
    exp_bus(32'h100, 0, 4'b1111, 0, 0, 32'hDEADBEEF, 0);
    exp_wb(32'hDEADBEEF, 1, 5'd5, 1, 0);
    issue(1, 32'h100, 0, 1, 0, 2'd0 + 2'd2, 0, 5'd5, 1);
    // signed byte load, 3 wait cycles
    exp_bus(32'h100, 0, 4'b1000, 0, 3, 32'h80FF_FFFF, 3);
    exp_wb(32'hFFFF_FF80, 1, 5'd6, 1, 0);
    issue(1, 32'h103, 0, 1, 0, 2'd0, 0, 5'd6, 1);
    // half store, 1 wait cycle
    exp_bus(32'h200, 1, 4'b1100, 32'hABCD_ABCD, 1, 0, 1);
    exp_wb(32'h202, 1, 5'd0, 0, 0);
    issue(1, 32'h202, 32'h1234_ABCD, 0, 1, 2'd1, 0, 5'd0, 0);
    // misaligned word load
    exp_wb(32'h0, 0, 5'd7, 0, 1);
    issue(1, 32'h101, 0, 1, 0, 2'd2, 0, 5'd7, 1);
    // unsigned half load, upper lane
    exp_bus(32'h104, 0, 4'b1100, 0, 0, 32'h8765_4321, 0);
    exp_wb(32'h0000_8765, 1, 5'd8, 1, 0);
    issue(1, 32'h106, 0, 1, 0, 2'd1, 1, 5'd8, 1);
    // signed half load, lower lane
    exp_bus(32'h104, 0, 4'b0011, 0, 0, 32'h1234_F00D, 0);
    exp_wb(32'hFFFF_F00D, 1, 5'd9, 1, 0);
    issue(1, 32'h104, 0, 1, 0, 2'd1, 0, 5'd9, 1);
    // unsigned byte load, lane 1, 2 wait cycles
    exp_bus(32'h200, 0, 4'b0010, 0, 2, 32'h1122_3344, 2);
    exp_wb(32'h0000_0033, 1, 5'd10, 1, 0);
    issue(1, 32'h201, 0, 1, 0, 2'd0, 1, 5'd10, 1);
    // byte store, lane 3
    exp_bus(32'h300, 1, 4'b1000, 32'hA5A5_A5A5, 0, 0, 0);
    exp_wb(32'h303, 1, 5'd0, 0, 0);
    issue(1, 32'h303, 32'hFFFF_12A5, 0, 1, 2'd0, 0, 5'd0, 0);
    // word store
    exp_bus(32'h40C, 1, 4'b1111, 32'hCAFE_F00D, 0, 0, 0);
    exp_wb(32'h40C, 1, 5'd0, 0, 0);
    issue(1, 32'h40C, 32'hCAFE_F00D, 0, 1, 2'd2, 0, 5'd0, 0);
    // ALU op passes through; forwarding tap
    exp_wb(32'h55AA, 1, 5'd11, 1, 0);
    issue(1, 32'h55AA, 32'h99, 0, 0, 2'd2, 0, 5'd11, 1);
    check("result_from_ex_mem", result_from_ex_mem, 32'h55AA);
    // bubble: no bus activity, no writeback
    issue(0, 32'h700, 0, 1, 0, 2'd2, 0, 5'd1, 1);
    // reserved size 3 behaves as word
    exp_bus(32'h110, 0, 4'b1111, 0, 0, 32'h0102_0304, 0);
    exp_wb(32'h0102_0304, 1, 5'd12, 1, 0);
    issue(1, 32'h110, 0, 1, 0, 2'd3, 0, 5'd12, 1);
    // misaligned half store
    exp_wb(32'h201, 0, 5'd0, 0, 1);
    issue(1, 32'h201, 32'hFFFF, 0, 1, 2'd1, 0, 5'd0, 0);
    // bus timeout: 15 stall cycles then error
    exp_bus(32'h500, 0, 4'b1111, 0, 1000, 0, 15);
    exp_wb(32'h0, 0, 5'd13, 0, 1);
    issue(1, 32'h500, 0, 1, 0, 2'd2, 0, 5'd13, 1);
    exp_wb(32'h77, 1, 5'd14, 1, 0);
    issue(1, 32'h77, 0, 0, 0, 2'd2, 0, 5'd14, 1);

    // reset in the middle of a wait
    repeat (2) @(negedge clock);
    #3;
    exp_bus(32'h600, 0, 4'b1111, 0, 1000, 0, -1);
    in_valid = 1'b1; ex_result = 32'h600; load_inst = 1'b1; ls_size = 2'd2;
    dest_reg = 5'd15; dest_reg_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0; load_inst = 1'b0;
    repeat (3) @(negedge clock);
    #5;
    check("pre_reset_dmem_req", 32'(dmem_req), 32'd1);
    check("pre_reset_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_dmem_req", 32'(dmem_req), 32'd0);
    check("mid_reset_stall", 32'(stall), 32'd0);
    check("mid_reset_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clock);
    #4 reset_n = 1'b1;
    @(negedge clock);
    #3;
    exp_wb(32'h88, 1, 5'd16, 1, 0);
    issue(1, 32'h88, 0, 0, 0, 2'd2, 0, 5'd16, 1);

    repeat (4) @(negedge clock);
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, bus wait cycles before a timeout is declared (legal range 2..255).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  EX stage presents a valid instruction.
REQ-005 SHALL have port ex_result  input  32  ALU result or load/store address from EX.
REQ-006 SHALL have port ex_result_2  input  32  forwarded B operand; store data.
REQ-007 SHALL have ports load_inst, store_inst  input  1 each  memory op type; never both set.
REQ-008 SHALL have port ls_size  input  2  0=byte, 1=half, 2=word; 3 reserved, treated as word.
REQ-009 SHALL have port ls_unsigned  input  1  zero-extend (1) or sign-extend (0) loads.
REQ-010 SHALL have ports dest_reg (input, 5) and dest_reg_valid (input, 1)  writeback target.
REQ-011 SHALL have port stall  output  1  freezes upstream stages; EX/MEM holds.
REQ-012 SHALL have port result_from_ex_mem  output  32  registered ex_result, for EX forwarding.
REQ-013 SHALL have ports dmem_req, dmem_we (output, 1), dmem_addr (output, 32, word aligned), dmem_be (output, 4), dmem_wdata (output, 32).
REQ-014 SHALL have ports dmem_ack (input, 1) and dmem_rdata (input, 32).
REQ-015 SHALL have ports wb_valid (output, 1), wb_result (output, 32), wb_dest_reg (output, 5), wb_dest_reg_valid (output, 1)  MEM/WB register; wb_result is also result_from_mem_wb.
REQ-016 SHALL have port mem_err  output  1  one-cycle pulse on misalignment or bus timeout.

Function
REQ-017 SHALL capture all EX inputs into the EX/MEM register on each edge where stall=0; hold when stall=1.
REQ-018 SHALL update the MEM/WB register on each edge where stall=0; wb_valid = EX/MEM valid.
REQ-019 SHALL run FSM IDLE/BUSY: IDLE->BUSY when EX/MEM holds a valid aligned memory op and dmem_ack=0; BUSY->IDLE on dmem_ack or timeout.
REQ-020 SHALL drive dmem_req=1 combinationally whenever EX/MEM holds a valid aligned memory op, in IDLE or BUSY; zero-wait ack (same cycle) completes with no stall.
REQ-021 SHALL assert stall = pending aligned memory op AND dmem_ack=0 AND not timing out.
REQ-022 SHALL keep dmem_addr, dmem_we, dmem_be, dmem_wdata stable while dmem_req=1 and dmem_ack=0.
REQ-023 SHALL set dmem_addr = {addr[31:2],2'b00}; byte be=1<<addr[1:0]; half be=addr[1]?4'b1100:4'b0011; word be=4'b1111; loads use the same be.
REQ-024 SHALL replicate store data to lanes: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-025 SHALL extract the load lane selected by addr[1:0] and sign/zero-extend per ls_unsigned into wb_result.
REQ-026 SHALL pass ex_result to wb_result for non-memory instructions and for stores.
REQ-027 SHALL treat half with addr[0]=1 or word with addr[1:0]!=0 as misaligned: no dmem_req, no stall, wb_dest_reg_valid=0, mem_err pulses on the edge it advances.
REQ-028 SHALL count BUSY cycles in a counter cleared on IDLE entry; when the count reaches TIMEOUT-1 without ack, the op completes that cycle with wb_dest_reg_valid=0 and mem_err pulse.
REQ-029 SHALL ignore dmem_ack when dmem_req=0.
REQ-030 SHALL propagate in_valid=0 as a bubble: no bus activity, wb_valid=0 next edge.

Reset
REQ-031 SHALL on reset_n=0 immediately clear FSM to IDLE, counter to 0, EX/MEM and MEM/WB valid bits, stall, dmem_req, dmem_we, mem_err, wb_valid, wb_dest_reg_valid; data registers reset to 0.
REQ-032 SHALL abandon any in-flight bus access on reset mid-operation; after release, first instruction is accepted on the first edge.

Verification
REQ-033 SHALL pass: word load addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall, next edge wb_result=0xDEADBEEF, wb_dest_reg_valid=1.
REQ-034 SHALL pass: signed byte load addr 0x103, rdata 0x80FF_FFFF, ack after 3 cycles -> stall=1 for 3 cycles, dmem_be=4'b1000, wb_result=0xFFFFFF80.
REQ-035 SHALL pass: half store addr 0x202, data 0x1234ABCD -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
REQ-036 SHALL pass: word load addr 0x101 -> dmem_req never 1, mem_err pulse, wb_dest_reg_valid=0.
REQ-037 SHALL pass: load with no ack, TIMEOUT=16 -> stall for 15 cycles, then release with mem_err pulse; reset_n low during a later wait -> dmem_req and stall drop immediately.
